fwuart_rx: RTL and testbench

//  UART receive stage, directly downstream of the baud-rate clock generator.
//  - Consumes its 16x-oversample enable (clock_x16) and the serial rxd line.
//  - Recovers 8N1 frames (8E1/8O1 with the parity option).
//  - Presents each byte on a valid/ready holding register with error flags.

---
 rtl/fwuart_rx.sv | 150 +++++++++++++++
 tb/tb_fwuart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwuart_rx.sv
// fwuart_rx: 16x-oversampled UART receiver, 8N1 or 8E1/8O1 when FWUART_RX_PARITY_EN is defined.
// Latency: byte is valid one clock after the mid-stop-bit sample.
// Backpressure: one-entry valid/ready holding register; a byte completing while full is dropped and flagged by overrun.
module fwuart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PARITY_ODD  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clock_x16,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef FWUART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   srx;
  logic [2:0]             state;
  logic [3:0]             cnt;
  logic [2:0]             bit_idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   done;
  logic                   load;

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign srx = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (clock_x16) begin
      cnt <= cnt + 4'd1;
      case (state)
        ST_IDLE: begin
          if (!srx) begin
            state <= ST_START;
            cnt   <= '0;
          end
        end
        ST_START: begin
          // A start bit that is high again at its midpoint was only a glitch.
          if (cnt == 4'd7) begin
            if (srx) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              cnt     <= '0;
              bit_idx <= '0;
            end
          end
        end
        ST_DATA: begin
          if (cnt == 4'd15) begin
            shreg   <= {srx, shreg[DATA_BITS-1:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == LAST_BIT) begin
`ifdef FWUART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef FWUART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == 4'd15) begin
            cnt   <= '0;
            state <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (cnt == 4'd15) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done = clock_x16 && (state == ST_STOP) && (cnt == 4'd15);
  assign load = done && (!rx_valid || rx_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= done && rx_valid && !rx_ready;
      if (load) begin
        rx_data   <= shreg;
        rx_valid  <= 1'b1;
        frame_err <= ~srx;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef FWUART_RX_PARITY_EN
  logic pbit;

  always_ff @(posedge clock) begin
    if (reset)
      pbit <= 1'b0;
    else if (clock_x16 && (state == ST_PARITY) && (cnt == 4'd15))
      pbit <= srx;
  end

  always_ff @(posedge clock) begin
    if (reset)
      parity_err <= 1'b0;
    else if (load)
      parity_err <= ((^shreg) ^ pbit) != 1'(PARITY_ODD);
  end
`else
  // Without a parity bit the parity sense has nothing to act on.
  logic unused_parity_sense;
  assign unused_parity_sense = 1'(PARITY_ODD);
  assign parity_err          = 1'b0;
`endif

endmodule

// File: tb/tb_fwuart_rx.sv
// Directed bench for fwuart_rx: one clock_x16 every 4 clocks, 64 clocks per bit.
// Honours FWUART_RX_PARITY_EN by inserting a parity bit in every frame.
module tb_fwuart_rx;

  logic       clock;
  logic       reset;
  logic       clock_x16;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int         ph;
  int         checks, passes, fails;
  int         hs_cnt, ovr_cnt;
  logic [7:0] last_data;
  logic       last_ferr, last_perr;
  int         lat, dummy, h0, o0;

  fwuart_rx dut (
    .clock      (clock),
    .reset      (reset),
    .clock_x16  (clock_x16),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  // Tick enable changes 2ns after the falling edge so it is stable at both edges.
  initial begin
    clock     = 1'b0;
    clock_x16 = 1'b0;
    ph        = 0;
    forever begin
      #2;
      ph        = (ph + 1) % 4;
      clock_x16 = (ph == 0);
      #3 clock = 1'b1;
      #5 clock = 1'b0;
    end
  end

  initial begin
    hs_cnt    = 0;
    ovr_cnt   = 0;
    last_data = '0;
    last_ferr = 1'b0;
    last_perr = 1'b0;
    forever begin
      @(negedge clock);
      #1;
      if (rx_valid && rx_ready) begin
        hs_cnt++;
        last_data = rx_data;
        last_ferr = frame_err;
        last_perr = parity_err;
      end
      if (overrun) ovr_cnt++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no completion, required finish before 3ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Sends one frame aligned to tick phase 0; optionally pulses rx_ready at
  // clock offset ready_at and reports the offset at which rx_valid first rose.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bad,
                            input int ready_at, output int rise);
    logic [11:0] bits;
    int          nbits;
    logic        was_low;
    bits     = '1;
    bits[0]  = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    bits[11] = (^d) ^ par_bad;
`ifdef FWUART_RX_PARITY_EN
    bits[9]  = bits[11];
    bits[10] = stop_bit;
    nbits    = 11;
`else
    bits[9]  = stop_bit;
    nbits    = 10;
`endif
    for (int i = 0; i < 8 && ph != 0; i++) @(negedge clock);
    rise    = -1;
    was_low = ~rx_valid;
    for (int c = 0; c < nbits * 64; c++) begin
      if (was_low && rise < 0 && rx_valid === 1'b1) rise = c;
      rxd = bits[c/64];
      if (ready_at >= 0 && c == ready_at) rx_ready = 1'b1;
      else if (ready_at >= 0 && c == ready_at + 1) rx_ready = 1'b0;
      @(negedge clock);
    end
    rxd = 1'b1;
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    fails    = 0;
    reset    = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    idle(4);
    chk("rst_data",   32'(rx_data), 32'h0);
    chk("rst_valid",  32'(rx_valid), 32'h0);
    chk("rst_ferr",   32'(frame_err), 32'h0);
    chk("rst_perr",   32'(parity_err), 32'h0);
    chk("rst_ovr",    32'(overrun), 32'h0);
    reset = 1'b0;
    idle(8);

    // 0xA5 with consumer always ready
    rx_ready = 1'b1;
    h0 = hs_cnt; o0 = ovr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, -1, lat);
    idle(128);
    chk("a5_count",  32'(hs_cnt - h0), 32'd1);
    chk("a5_data",   32'(last_data), 32'hA5);
    chk("a5_ferr",   32'(last_ferr), 32'h0);
    chk("a5_ovr",    32'(ovr_cnt - o0), 32'd0);
    chk("a5_vld_lo", 32'(rx_valid), 32'h0);
    chk("a5_rise",   32'(lat > 0), 32'h1);

    // 4-tick low glitch, then a real frame
    h0 = hs_cnt;
    for (int i = 0; i < 8 && ph != 0; i++) @(negedge clock);
    rxd = 1'b0;
    idle(16);
    rxd = 1'b1;
    idle(128);
    chk("glitch_count", 32'(hs_cnt - h0), 32'd0);
    chk("glitch_vld",   32'(rx_valid), 32'h0);
    send_frame(8'h3C, 1'b1, 1'b0, -1, dummy);
    idle(128);
    chk("3c_count", 32'(hs_cnt - h0), 32'd1);
    chk("3c_data",  32'(last_data), 32'h3C);

    // framing error then recovery
    h0 = hs_cnt;
    send_frame(8'h55, 1'b0, 1'b0, -1, dummy);
    idle(128);
    chk("55_count", 32'(hs_cnt - h0), 32'd1);
    chk("55_data",  32'(last_data), 32'h55);
    chk("55_ferr",  32'(last_ferr), 32'h1);
    send_frame(8'h01, 1'b1, 1'b0, -1, dummy);
    idle(128);
    chk("01_data",  32'(last_data), 32'h01);
    chk("01_ferr",  32'(last_ferr), 32'h0);

    // overrun: second byte dropped while register is full
    rx_ready = 1'b0;
    h0 = hs_cnt; o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, 1'b0, -1, dummy);
    idle(64);
    send_frame(8'h22, 1'b1, 1'b0, -1, dummy);
    idle(64);
    chk("ovr_vld",   32'(rx_valid), 32'h1);
    chk("ovr_data",  32'(rx_data), 32'h11);
    chk("ovr_pulse", 32'(ovr_cnt - o0), 32'd1);
    chk("ovr_hs",    32'(hs_cnt - h0), 32'd0);
    rx_ready = 1'b1;
    @(negedge clock);
    rx_ready = 1'b0;
    chk("drain_vld",  32'(rx_valid), 32'h0);
    chk("drain_data", 32'(rx_data), 32'h11);

    // accept and load in the same cycle
    h0 = hs_cnt;
    send_frame(8'h11, 1'b1, 1'b0, -1, dummy);
    idle(64);
    o0 = ovr_cnt;
    send_frame(8'h22, 1'b1, 1'b0, lat - 1, dummy);
    idle(64);
    chk("sim_vld",  32'(rx_valid), 32'h1);
    chk("sim_data", 32'(rx_data), 32'h22);
    chk("sim_ovr",  32'(ovr_cnt - o0), 32'd0);
    chk("sim_hs",   32'(hs_cnt - h0), 32'd1);

    // reset in the middle of the data bits of 0xFF
    for (int i = 0; i < 8 && ph != 0; i++) @(negedge clock);
    rxd = 1'b0;
    idle(64);
    rxd = 1'b1;
    idle(192);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_data",  32'(rx_data), 32'h0);
    chk("mid_rst_valid", 32'(rx_valid), 32'h0);
    chk("mid_rst_ferr",  32'(frame_err), 32'h0);
    chk("mid_rst_perr",  32'(parity_err), 32'h0);
    chk("mid_rst_ovr",   32'(overrun), 32'h0);
    reset = 1'b0;
    idle(128);
    rx_ready = 1'b1;
    h0 = hs_cnt;
    send_frame(8'h80, 1'b1, 1'b1, -1, dummy);
    idle(64);
    chk("80_count", 32'(hs_cnt - h0), 32'd1);
    chk("80_data",  32'(last_data), 32'h80);
    chk("80_ferr",  32'(last_ferr), 32'h0);
`ifdef FWUART_RX_PARITY_EN
    chk("80_perr",  32'(last_perr), 32'h1);
`else
    chk("80_perr",  32'(last_perr), 32'h0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
